bomba_piscina_ctrl: RTL and testbench



---
 rtl/bomba_pkg.sv | 22 ++
 rtl/sol_debounce.sv | 44 ++++
 rtl/bomba_piscina_ctrl.sv | 134 +++++++++++++
 tb/tb_bomba_piscina_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bomba_pkg.sv
// Shared types and 7-segment codes for the pool-pump power-source controller.
package bomba_pkg;

  typedef enum logic [1:0] {
    DESLIGADO     = 2'd0,
    PAINEL_SOLAR  = 2'd1,
    REDE_ELETRICA = 2'd2
  } estado_t;

  localparam logic [7:0] SEG_DESL  = 8'h3F;
  localparam logic [7:0] SEG_SOLAR = 8'h06;
  localparam logic [7:0] SEG_REDE  = 8'h5B;

  function automatic logic [7:0] seg_decode(input estado_t e);
    case (e)
      PAINEL_SOLAR:  return SEG_SOLAR;
      REDE_ELETRICA: return SEG_REDE;
      default:       return SEG_DESL;
    endcase
  endfunction

endpackage

// File: rtl/sol_debounce.sv
// Sun-sensor debouncer: sol_f follows the registered sample once it has been
// stable for SUN_DEBOUNCE consecutive edges.
module sol_debounce #(
  parameter int SUN_DEBOUNCE = 2
) (
  input  logic clk_2,
  input  logic reset,
  input  logic sol,
  output logic sol_f
);

  localparam int ST_W = $clog2(SUN_DEBOUNCE + 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(SUN_DEBOUNCE);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SUN_DEBOUNCE - 1);

  logic            r_sol_q;
  logic [ST_W-1:0] r_stab;
  logic            r_sol_f;
  logic            w_same;

  // The sample about to be registered equals the current one: the run extends.
  assign w_same = (sol == r_sol_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_sol_q <= 1'b0;
      r_stab  <= '0;
      r_sol_f <= 1'b0;
    end else begin
      r_sol_q <= sol;
      if (w_same) begin
        if (r_stab != ST_MAX) r_stab <= r_stab + 1'b1;
        if (r_stab >= ST_LAST) r_sol_f <= r_sol_q;
      end else begin
        r_stab <= '0;
      end
    end
  end

  assign sol_f = r_sol_f;

endmodule

// File: rtl/bomba_piscina_ctrl.sv
// Pool-pump power-source controller: solar/grid selection, grid dwell and panel PWM.
// Optional macro BOMBA_SEG_EN enables the registered 7-segment state decode on seg.
module bomba_piscina_ctrl
  import bomba_pkg::*;
#(
  parameter int CNT_BITS     = 3,
  parameter int GRID_DELAY   = 4,
  parameter int MIN_GRID     = 3,
  parameter int SUN_DEBOUNCE = 2,
  parameter int DUTY_PERIOD  = 2,
  parameter int DUTY_ON      = 1
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                habilita,
  input  logic                sol,
  output logic                painel,
  output logic                rede,
  output logic [1:0]          estado,
  output logic [CNT_BITS-1:0] contador,
  output logic                sol_f,
  output logic [7:0]          seg
);

  localparam int PH_W = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;
  localparam logic [CNT_BITS-1:0] GD_LAST = CNT_BITS'(GRID_DELAY - 1);
  localparam logic [CNT_BITS-1:0] MG_MAX  = CNT_BITS'(MIN_GRID);
  localparam logic [PH_W-1:0]     PH_LAST = PH_W'(DUTY_PERIOD - 1);
  localparam logic [PH_W:0]       DON     = (PH_W + 1)'(DUTY_ON);

  estado_t             r_estado;
  logic [CNT_BITS-1:0] r_cnt;
  logic [PH_W-1:0]     r_phase;

  estado_t             w_estado_nxt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic [PH_W-1:0]     w_phase_nxt;
  logic                w_sol_f;

  sol_debounce #(
    .SUN_DEBOUNCE(SUN_DEBOUNCE)
  ) u_sol_debounce (
    .clk_2 (clk_2),
    .reset (reset),
    .sol   (sol),
    .sol_f (w_sol_f)
  );

  // NOTE: every next-state variable gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_estado_nxt = r_estado;
    w_cnt_nxt    = r_cnt;
    w_phase_nxt  = r_phase;
    if (!habilita) begin
      w_estado_nxt = DESLIGADO;
      w_cnt_nxt    = '0;
      w_phase_nxt  = '0;
    end else begin
      case (r_estado)
        DESLIGADO: begin
          if (w_sol_f) begin
            w_estado_nxt = PAINEL_SOLAR;
            w_cnt_nxt    = '0;
            w_phase_nxt  = '0;
          end else if (r_cnt == GD_LAST) begin
            w_estado_nxt = REDE_ELETRICA;
            w_cnt_nxt    = '0;
            w_phase_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        PAINEL_SOLAR: begin
          if (!w_sol_f) begin
            w_estado_nxt = DESLIGADO;
            w_cnt_nxt    = '0;
            w_phase_nxt  = '0;
          end else begin
            w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
          end
        end
        REDE_ELETRICA: begin
          // Sun is ignored until the minimum grid dwell has elapsed.
          if (w_sol_f && (r_cnt == MG_MAX)) begin
            w_estado_nxt = PAINEL_SOLAR;
            w_cnt_nxt    = '0;
            w_phase_nxt  = '0;
          end else if (r_cnt != MG_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_estado_nxt = DESLIGADO;
          w_cnt_nxt    = '0;
          w_phase_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_estado <= DESLIGADO;
      r_cnt    <= '0;
      r_phase  <= '0;
    end else begin
      r_estado <= w_estado_nxt;
      r_cnt    <= w_cnt_nxt;
      r_phase  <= w_phase_nxt;
    end
  end

`ifdef BOMBA_SEG_EN
  logic [7:0] r_seg;

  // Decoding the next state keeps seg aligned with estado on the same edge.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) r_seg <= SEG_DESL;
    else       r_seg <= seg_decode(w_estado_nxt);
  end

  assign seg = r_seg;
`else
  assign seg = 8'h00;
`endif

  assign painel   = (r_estado == PAINEL_SOLAR) && ({1'b0, r_phase} < DON);
  assign rede     = (r_estado == REDE_ELETRICA);
  assign estado   = r_estado;
  assign contador = r_cnt;
  assign sol_f    = w_sol_f;

endmodule

// File: tb/tb_bomba_piscina_ctrl.sv
// Directed self-checking bench for bomba_piscina_ctrl at default parameters.
module tb_bomba_piscina_ctrl;

`ifdef BOMBA_SEG_EN
  localparam int SEG_D = 'h3F;
  localparam int SEG_S = 'h06;
  localparam int SEG_R = 'h5B;
`else
  localparam int SEG_D = 0;
  localparam int SEG_S = 0;
  localparam int SEG_R = 0;
`endif

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       habilita;
  logic       sol;
  logic       painel;
  logic       rede;
  logic [1:0] estado;
  logic [2:0] contador;
  logic       sol_f;
  logic [7:0] seg;

  int n_checks = 0;
  int n_errors = 0;

  bomba_piscina_ctrl dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .habilita (habilita),
    .sol      (sol),
    .painel   (painel),
    .rede     (rede),
    .estado   (estado),
    .contador (contador),
    .sol_f    (sol_f),
    .seg      (seg)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    @(negedge clk_2);
  endtask

  initial begin
    reset    = 1'b1;
    habilita = 1'b0;
    sol      = 1'b0;
    step();
    step();
    check("rst_estado", 32'(estado), 0);
    check("rst_cnt", 32'(contador), 0);
    check("rst_sol_f", 32'(sol_f), 0);
    check("rst_painel", 32'(painel), 0);
    check("rst_rede", 32'(rede), 0);
    check("rst_seg", 32'(seg), SEG_D);

    // 1: no sun, grid after GRID_DELAY edges
    reset    = 1'b0;
    habilita = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      check("t1_cnt", 32'(contador), e);
      check("t1_estado", 32'(estado), 0);
      check("t1_painel", 32'(painel), 0);
    end
    step();
    check("t1_estado_rede", 32'(estado), 2);
    check("t1_rede", 32'(rede), 1);
    check("t1_cnt_entry", 32'(contador), 0);
    check("t1_painel_off", 32'(painel), 0);
    check("t1_seg", 32'(seg), SEG_R);

    // 2: sun during the grid dwell is held off until contador==MIN_GRID
    sol = 1'b1;
    step();
    check("t2_cnt1", 32'(contador), 1);
    check("t2_solf_a", 32'(sol_f), 0);
    step();
    check("t2_cnt2", 32'(contador), 2);
    check("t2_solf_b", 32'(sol_f), 0);
    step();
    check("t2_cnt3", 32'(contador), 3);
    check("t2_solf_c", 32'(sol_f), 1);
    check("t2_still_rede", 32'(estado), 2);
    check("t2_rede_on", 32'(rede), 1);
    step();
    check("t2_solar", 32'(estado), 1);
    check("t2_rede_drop", 32'(rede), 0);
    check("t2_cnt_entry", 32'(contador), 0);
    check("t2_seg", 32'(seg), SEG_S);

    // 3: PWM pattern 1,0,1,0,... with DUTY_ON=1 of DUTY_PERIOD=2
    for (int i = 0; i < 8; i++) begin
      check("t3_painel", 32'(painel), (i % 2 == 0) ? 1 : 0);
      check("t3_rede", 32'(rede), 0);
      step();
    end

    // 4: a one-cycle dropout is filtered; a held dropout returns to DESLIGADO
    sol = 1'b0;
    step();
    sol = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_glitch_solf", 32'(sol_f), 1);
      check("t4_glitch_estado", 32'(estado), 1);
      step();
    end
    sol = 1'b0;
    step();
    check("t4_solf_hold1", 32'(sol_f), 1);
    step();
    check("t4_solf_hold2", 32'(sol_f), 1);
    step();
    check("t4_solf_drop", 32'(sol_f), 0);
    check("t4_estado_lag", 32'(estado), 1);
    step();
    check("t4_desl", 32'(estado), 0);
    check("t4_painel_off", 32'(painel), 0);
    check("t4_cnt0", 32'(contador), 0);
    check("t4_seg", 32'(seg), SEG_D);

    // 5: habilita=0 clears and freezes contador
    step();
    step();
    check("t5_cnt2", 32'(contador), 2);
    habilita = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_cnt_held", 32'(contador), 0);
      check("t5_estado_desl", 32'(estado), 0);
    end
    habilita = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      check("t5_reen_cnt", 32'(contador), e);
      check("t5_reen_estado", 32'(estado), 0);
    end
    step();
    check("t5_rede", 32'(estado), 2);
    check("t5_rede_out", 32'(rede), 1);

    // 6: asynchronous reset between clock edges
    step();
    check("t6_pre_rede", 32'(rede), 1);
    check("t6_pre_cnt", 32'(contador), 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rede", 32'(rede), 0);
    check("t6_estado", 32'(estado), 0);
    check("t6_cnt", 32'(contador), 0);
    check("t6_seg", 32'(seg), SEG_D);
    check("t6_sol_f", 32'(sol_f), 0);
    step();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
